// File: rtl/register_chain_loader.sv
// Serial configuration chain loader: shifts a parallel word into a chain of register
// cells, strobes the cell update, and returns the previous chain contents as a readback word.
module register_chain_loader #(
  parameter int unsigned CHAIN_LEN     = 8,
  parameter int unsigned UPDATE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHAIN_LEN-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 chain_in,
  output logic                 chain_enable,
  output logic                 chain_update,
  input  logic                 chain_return,
  output logic [CHAIN_LEN-1:0] rb_data,
  output logic                 rb_valid,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned UPD_W = $clog2(UPDATE_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] UPDATE = 2'd3;

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [CHAIN_LEN-1:0] shift_q;
  logic [CHAIN_LEN-1:0] rb_shift_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [UPD_W-1:0]     upd_q;
  logic                 accept;
  logic                 enable_d;
  logic                 update_d;
  logic                 busy_d;
  logic                 ready_d;
  logic                 rb_valid_d;

  // Serial data always comes straight from the shift register MSB
  assign chain_in = shift_q[CHAIN_LEN-1];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next values of the registered chain-facing outputs
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        state_d = UPDATE;
      end
      UPDATE: begin
        if (upd_q == UPD_W'(UPDATE_CYCLES - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    enable_d   = (state_d == SHIFT);
    update_d   = (state_d == UPDATE);
    busy_d     = (state_d != IDLE);
    ready_d    = (state_d == IDLE);
    rb_valid_d = (state_q == UPDATE) && (state_d == IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q      <= '0;
      rb_shift_q   <= '0;
      rb_data      <= '0;
      rb_valid     <= 1'b0;
      cnt_q        <= '0;
      upd_q        <= '0;
      in_ready     <= 1'b0;
      chain_enable <= 1'b0;
      chain_update <= 1'b0;
      busy         <= 1'b0;
    end else begin
      in_ready     <= ready_d;
      chain_enable <= enable_d;
      chain_update <= update_d;
      busy         <= busy_d;
      rb_valid     <= rb_valid_d;
      if (rb_valid_d) begin
        rb_data <= rb_shift_q;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= in_data;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          // Tail bit is sampled before this shift moves the chain
          shift_q    <= shift_q << 1;
          rb_shift_q <= CHAIN_LEN'({rb_shift_q, chain_return});
          cnt_q      <= cnt_q + CNT_W'(1);
        end
        SETTLE: begin
          upd_q <= '0;
        end
        UPDATE: begin
          upd_q <= upd_q + UPD_W'(1);
        end
        default: begin
          upd_q <= '0;
        end
      endcase
    end
  end

endmodule
